// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  // Read data handed back to the owner when the backing memory never answers.
  localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the CPU ports, the arbiter and the backing memory.
// slave = arbiter side, master = CPU/memory environment side.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  // data-memory port
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  // backing memory
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  // hazard / status
  logic              stall_if;
  logic              stall_mem;
  logic              err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, err
  );
endinterface

// File: rtl/mem_arb_timer.sv
// Saturating up-counter with clear/enable; tc flags that the count sits at MAX.
module mem_arb_timer #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  // clear has priority; counting stops once MAX is reached
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                      cnt_d = '0;
    else if (en && cnt_q != MAX_V) cnt_d = cnt_q + 1'b1;
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == MAX_V);
endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between IF (read-only) and MEM (read/write).
// DM wins by default; IF is forced through after STARVE_LIMIT DM grants made
// while it was waiting. Transactions that see no ack within TIMEOUT cycles
// complete with zero data and set a sticky err.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  unified_mem_arbiter_if.slave bus
);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;
  logic              err_q, err_d;

  logic              if_grant, dm_grant, to_tc, starve_tc;
  logic [ADDR_W-1:0] sel_addr;

  // grant decision only matters in IDLE; starved IF overrides DM priority
  assign if_grant = (state_q == IDLE) && bus.if_req && (!bus.dm_req || starve_tc);
  assign dm_grant = (state_q == IDLE) && bus.dm_req && !if_grant;
  assign sel_addr = if_grant ? bus.if_addr : bus.dm_addr;

  // index of the BUSY cycle; terminal at TIMEOUT-1
  mem_arb_timer #(.MAX(TIMEOUT - 1)) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (state_q != BUSY),
    .en  (state_q == BUSY),
    .tc  (to_tc)
  );

  // DM grants taken while IF was waiting
  mem_arb_timer #(.MAX(STARVE_LIMIT)) u_starve (
    .clk (clk),
    .rst (rst),
    .clr (if_grant),
    .en  (dm_grant && bus.if_req),
    .tc  (starve_tc)
  );

  // next-state and datapath: grant in IDLE, wait for ack/timeout in BUSY, pulse valid in RESP
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (if_grant || dm_grant) begin
          owner_d    = if_grant ? OWN_IF : OWN_DM;
          mem_req_d  = 1'b1;
          mem_we_d   = dm_grant && bus.dm_we;
          mem_addr_d = sel_addr & ALIGN_MASK;
          if (dm_grant) mem_wdata_d = bus.dm_wdata;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        // an ack coinciding with the terminal count still wins
        if (bus.mem_ack || to_tc) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = RESP;
          if (!bus.mem_ack) err_d = 1'b1;
          if (owner_q == OWN_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.mem_ack ? bus.mem_rdata : DATA_W'(ERR_RDATA);
          end else begin
            dm_valid_d = 1'b1;
            if (!bus.mem_ack)    dm_rdata_d = DATA_W'(ERR_RDATA);
            else if (!mem_we_q)  dm_rdata_d = bus.mem_rdata;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.dm_valid  = dm_valid_q;
  assign bus.err       = err_q;
  // stalls drop in the valid cycle so the pipeline advances exactly once
  assign bus.stall_if  = bus.if_req & ~if_valid_q;
  assign bus.stall_mem = bus.dm_req & ~dm_valid_q;
endmodule
